// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  localparam int unsigned WordBytes = 4;

  // States in which the loader takes bytes from the stream.
  function automatic logic is_rx_state(state_e s);
    return s inside {StLenHi, StLenLo, StData, StCheck};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/byte_to_word.sv
// Packs four stream bytes, MSB first, into a 32-bit word with a one-cycle valid pulse.
module byte_to_word
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  assign last_byte = in_valid && (cnt_q == 2'(WordBytes - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= last_byte;
      if (clear) begin
        cnt_q <= '0;
      end else if (in_valid) begin
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {shift_q[15:0], in_data};
        if (last_byte) begin
          word <= {shift_q, in_data};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/data/checksum byte frame and writes words to instruction memory.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam int unsigned IdxW = $clog2(MAX_WORDS) + 1;

  state_e          state_q, state_d;
  logic [7:0]      len_hi_q;
  logic [15:0]     len_q;
  logic [7:0]      xor_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wr_addr_q;
  logic            byte_ready_q;

  logic        xfer;
  logic        load_start;
  logic        data_byte;
  logic        last_byte;
  logic        last_word;
  logic [15:0] len_in;

  assign xfer       = bus.byte_valid && byte_ready_q;
  assign load_start = start && (state_q inside {StIdle, StDone, StError});
  assign data_byte  = xfer && (state_q == StData);
  assign len_in     = {len_hi_q, bus.byte_data};
  assign last_word  = (32'(idx_q) + 32'd1) == 32'(len_q);

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_addr    = wr_addr_q;

  byte_to_word u_byte_to_word (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .in_valid   (data_byte),
    .in_data    (bus.byte_data),
    .last_byte  (last_byte),
    .word_valid (bus.wr_en),
    .word       (bus.wr_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (start) state_d = StLenHi;
      StLenHi: if (xfer) state_d = StLenLo;
      StLenLo: begin
        if (xfer) begin
          if (32'(len_in) > MAX_WORDS) state_d = StError;
          else if (len_in == 16'd0)    state_d = StCheck;
          else                         state_d = StData;
        end
      end
      StData:  if (last_byte && last_word) state_d = StCheck;
      StCheck: if (xfer) state_d = (bus.byte_data == xor_q) ? StDone : StError;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they change together with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      byte_ready_q <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      len_hi_q     <= '0;
      len_q        <= '0;
      xor_q        <= '0;
      idx_q        <= '0;
      wr_addr_q    <= BASE_ADDR;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= is_rx_state(state_d);
      cpu_hold     <= !(state_d inside {StIdle, StDone});
      done         <= (state_d == StDone);
      error        <= (state_d == StError);

      if (load_start) begin
        xor_q <= '0;
        idx_q <= '0;
      end else begin
        if (xfer && (state_q != StCheck)) xor_q <= xor_q ^ bus.byte_data;
        if (last_byte) begin
          wr_addr_q <= BASE_ADDR + (32'(idx_q) << 2);
          idx_q     <= idx_q + 1'b1;
        end
      end

      if (xfer && (state_q == StLenHi)) len_hi_q <= bus.byte_data;
      if (xfer && (state_q == StLenLo)) len_q <= len_in;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, hand sequences and random frames.
module tb_imem_loader;

  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int unsigned MAX_WORDS = 256;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, done, error;

  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader #(
    .BASE_ADDR (BASE_ADDR),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  typedef struct packed {
    logic [3:0]  nbytes;
    logic [63:0] bytes;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  nwr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs [4];

  int checks = 0;
  int failures = 0;

  logic [7:0]  frame_q [$];
  logic [63:0] exp_w_q [$];
  logic [63:0] obs_q [$];
  logic        exp_done, exp_err;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_addr, bus.wr_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns at a falling edge; gap_pct is the chance of an idle cycle before the byte.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct);
    int g;
    while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    g = 0;
    while (!bus.byte_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!bus.byte_ready) begin
      check("byte_ready_timeout", 64'(bus.byte_ready), 64'd1);
    end else begin
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'(BASE_ADDR));
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
  endtask

  // Reference model: builds a frame of n random words and the writes/outcome it must produce.
  task automatic model_build(input int unsigned n, input bit corrupt);
    logic [7:0]  chk;
    logic [31:0] w;
    frame_q.delete();
    exp_w_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    if (n > MAX_WORDS) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = $urandom;
      for (int k = 3; k >= 0; k--) frame_q.push_back(8'(w >> (8 * k)));
      exp_w_q.push_back({BASE_ADDR + 32'(4 * i), w});
    end
    chk = 8'd0;
    foreach (frame_q[j]) chk ^= frame_q[j];
    if (corrupt) chk ^= 8'(1 << $urandom_range(7));
    frame_q.push_back(chk);
    exp_done = !corrupt;
    exp_err  = corrupt;
  endtask

  task automatic run_frame(input int unsigned gap_pct, input bit hold_start);
    int n;
    obs_q.delete();
    do_start();
    check("start_clears_done", 64'(done), 64'd0);
    check("start_clears_error", 64'(error), 64'd0);
    check("start_byte_ready", 64'(bus.byte_ready), 64'd1);
    check("start_cpu_hold", 64'(cpu_hold), 64'd1);
    n = frame_q.size();
    for (int j = 0; j < n; j++) begin
      if (hold_start && j == 2) start = 1'b1;
      if (hold_start && j == n - 1) start = 1'b0;
      send_byte(frame_q[j], gap_pct);
    end
    start = 1'b0;
    check("end_done", 64'(done), 64'(exp_done));
    check("end_error", 64'(error), 64'(exp_err));
    check("end_cpu_hold", 64'(cpu_hold), 64'(!exp_done));
    check("end_byte_ready", 64'(bus.byte_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("done_sticky", 64'(done), 64'(exp_done));
    check("wr_count", 64'(obs_q.size()), 64'(exp_w_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_w_q.size(); i++) begin
      check("wr_addr", 64'(obs_q[i][63:32]), 64'(exp_w_q[i][63:32]));
      check("wr_data", 64'(obs_q[i][31:0]), 64'(exp_w_q[i][31:0]));
    end
  endtask

  initial begin
    logic [63:0] tmp;
    reset = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{nbytes: 4'd7, bytes: 64'h0001_2008_0005_2C00, exp_done: 1'b1, exp_err: 1'b0,
                nwr: 2'd1, wdata: 32'h2008_0005};
    vecs[1] = '{nbytes: 4'd7, bytes: 64'h0001_2008_0005_2D00, exp_done: 1'b0, exp_err: 1'b1,
                nwr: 2'd1, wdata: 32'h2008_0005};
    vecs[2] = '{nbytes: 4'd2, bytes: 64'h0101_0000_0000_0000, exp_done: 1'b0, exp_err: 1'b1,
                nwr: 2'd0, wdata: 32'h0};
    vecs[3] = '{nbytes: 4'd3, bytes: 64'h0000_0000_0000_0000, exp_done: 1'b1, exp_err: 1'b0,
                nwr: 2'd0, wdata: 32'h0};

    for (int v = 0; v < 4; v++) begin
      tmp = vecs[v].bytes;
      frame_q.delete();
      exp_w_q.delete();
      for (int k = 0; k < int'(vecs[v].nbytes); k++) frame_q.push_back(tmp[63 - 8 * k -: 8]);
      for (int k = 0; k < int'(vecs[v].nwr); k++) exp_w_q.push_back({BASE_ADDR, vecs[v].wdata});
      exp_done = vecs[v].exp_done;
      exp_err  = vecs[v].exp_err;
      run_frame(0, 1'b0);
    end

    // Write strobe lands exactly one cycle after the 4th data byte.
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    check("wr_en_early", 64'(bus.wr_en), 64'd0);
    send_byte(8'h05, 0);
    check("wr_en_latency", 64'(bus.wr_en), 64'd1);
    check("wr_addr_single", 64'(bus.wr_addr), 64'(BASE_ADDR));
    check("wr_data_single", 64'(bus.wr_data), 64'h2008_0005);
    check("hold_before_chk", 64'(cpu_hold), 64'd1);
    send_byte(8'h2C, 0);
    check("done_after_chk", 64'(done), 64'd1);
    check("hold_released", 64'(cpu_hold), 64'd0);
    check("wr_en_single_pulse", 64'(bus.wr_en), 64'd0);

    // Three words with idle gaps; start held mid-load must be ignored.
    model_build(3, 1'b0);
    run_frame(40, 1'b1);

    // Abort mid-load, then reload and reload again from DONE.
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    model_build(2, 1'b0);
    run_frame(0, 1'b0);
    model_build(1, 1'b0);
    run_frame(0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      model_build($urandom_range(0, 6), ($urandom_range(3) == 0));
      run_frame($urandom_range(0, 50), 1'b0);
    end
    model_build($urandom_range(MAX_WORDS + 1, 65535), 1'b0);
    run_frame(20, 1'b0);
    model_build(MAX_WORDS, 1'b0);
    run_frame(10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the fetch stage reads. Receives a framed byte stream (length, big-endian instruction words, XOR checksum) over a valid/ready handshake. Writes each assembled 32-bit word to consecutive word addresses. Holds the CPU in reset until the image is complete, so the PC restarts at 0 on the freshly loaded program.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, default 256: largest accepted image, in words. Must be a power of two, ≤ 65535.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: begins a load. Sampled only in IDLE, DONE or ERROR.
- `byte_valid` input 1: the source has a byte on `byte_data`.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: the loader accepts a byte this cycle. A transfer occurs when `byte_valid` and `byte_ready` are both 1.
- `wr_en` output 1: instruction-memory write strobe, one cycle per word.
- `wr_addr` output 32: word-aligned byte address for the write.
- `wr_data` output 32: instruction word.
- `cpu_hold` output 1: level, ORed into the CPU reset by the integrator.
- `done` output 1: image loaded and checksum good.
- `error` output 1: oversize length or checksum mismatch.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, MSB first.
  - 4·N data bytes: each word MSB first (big-endian, MIPS order).
  - One CHK byte, equal to the XOR of every preceding frame byte, including the length bytes.
- States and transitions:
  - IDLE → LEN_HI on `start`.
  - LEN_HI → LEN_LO on a transfer.
  - LEN_LO → DATA on a transfer, or → CHECK if N = 0. If N > MAX_WORDS, go to ERROR instead; the LEN_LO byte is consumed.
  - DATA: after the 4th byte of word i, go to DATA (next word) or, if i = N−1, to CHECK.
  - CHECK → DONE if the received byte equals the running XOR, else → ERROR.
  - DONE or ERROR → LEN_HI on `start`. This clears `done`/`error`, the word index and the running XOR.
- `byte_ready` = 1 exactly in LEN_HI, LEN_LO, DATA and CHECK. The loader never back-pressures mid-frame.
- Write port:
  - `wr_en` pulses in the cycle after the transfer of a word's 4th byte.
  - `wr_addr` = BASE_ADDR + 4·i, with i starting at 0.
  - `wr_data` = {b0, b1, b2, b3} in arrival order.
  - `wr_addr`/`wr_data` hold their last values when `wr_en` = 0.
- `cpu_hold` = 1 in every state except DONE and IDLE.
- Words already written before an ERROR are not rolled back. The CPU stays held.
- `start` asserted during an active load is ignored.
- `byte_valid` with `byte_ready` = 0 is ignored, and the byte is not consumed.

## Timing
- Reset values: state IDLE; `byte_ready`, `wr_en`, `done`, `error`, `cpu_hold` all 0; `wr_addr` = BASE_ADDR; `wr_data` = 0; word index, byte counter and running XOR all 0.
- `reset` asserted mid-load aborts immediately to IDLE with all reset values. Partial memory contents are left as written.
- Throughput: one byte per cycle; a back-to-back word costs 4 cycles.
- Write latency: 1 cycle after the 4th byte transfer.
- `done`/`error` assert in the cycle after the CHK transfer and stay high until `start` or `reset`.
- If the last word's write pulse and the CHK transfer are in the same cycle, both are serviced.
- `cpu_hold` falls in the same cycle `done` rises.
- Word index width: clog2(MAX_WORDS)+1; it never wraps because N ≤ MAX_WORDS is enforced.

## Structure
- Shared package `loader_pkg`: state encodings (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR) and the frame-field byte counts.
- Sub-module `byte_to_word`: 4-byte shift register with a 2-bit counter and a registered `word_valid` pulse.
- The FSM, address counter and XOR accumulator stay in `imem_loader`.

## Test plan
- Single word: N = 1, bytes 00 01 20 08 00 05 2C → one `wr_en` pulse with `wr_addr` = 0x0, `wr_data` = 0x2008_0005; then `done` = 1, `cpu_hold` = 0.
- Three words sent with random `byte_valid` gaps → writes to 0x0, 0x4, 0x8 in order with the correct data; the bytes seen during gaps are not consumed.
- Bad checksum: the single-word frame with CHK = 2D → write still occurs; then `error` = 1, `done` = 0, `cpu_hold` = 1.
- Oversize: with MAX_WORDS = 256, length bytes 01 01 → ERROR after LEN_LO; `byte_ready` = 0; no `wr_en`.
- Empty image: bytes 00 00 00 → `done` = 1 with no writes.
- Abort and reload: `reset` after 2 data bytes → all outputs at reset values. Then a fresh `start` plus a valid frame → normal load from `wr_addr` = 0x0. A second `start` from DONE reloads and clears `done`.
